// File: rtl/rsi_calc.sv
// rsi_calc: windowed RSI from a price stream via ring-buffered gain/loss sums and a 45-step restoring divider; define RSI_ROUND_EN for round-half-up
module rsi_calc #(
    parameter int WINDOW = 14
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] price_in,
    input  logic        price_valid,
    output logic        price_ready,
    output logic [31:0] rsi_,
    output logic        rsi_valid,
    output logic        warm
);
    localparam int PW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int CW = $clog2(WINDOW + 1);
    typedef enum logic [1:0] {IDLE, UPDATE, DIVIDE, DONE} state_t;
    state_t r_state, w_next;
    logic [31:0] r_prev, r_gain, r_loss, r_rsi;
    logic        r_have_prev, r_warm, w_warm, w_ge;
    logic [31:0] r_ring_g [WINDOW];
    logic [31:0] r_ring_l [WINDOW];
    logic [PW-1:0] r_ptr;
    logic [CW-1:0] r_cnt;
    logic [37:0] r_gsum, r_lsum, w_gsum, w_lsum;
    logic [38:0] r_den, r_rem, w_den;
    logic [44:0] r_num, w_num;
    logic [39:0] w_trial;
    logic [5:0]  r_step;
    always_comb begin
        w_gsum  = r_gsum - 38'(r_ring_g[r_ptr]) + 38'(r_gain);
        w_lsum  = r_lsum - 38'(r_ring_l[r_ptr]) + 38'(r_loss);
        w_den   = 39'(w_gsum) + 39'(w_lsum);
`ifdef RSI_ROUND_EN
        w_num   = 45'(w_gsum) * 45'd100 + 45'(w_den >> 1);
`else
        w_num   = 45'(w_gsum) * 45'd100;
`endif
        w_warm  = r_warm || (r_cnt == CW'(WINDOW - 1));
        w_trial = {r_rem, r_num[44]};
        w_ge    = w_trial >= {1'b0, r_den};
        w_next  = r_state;
        case (r_state)
            IDLE:    w_next = (price_valid && r_have_prev) ? UPDATE : IDLE;
            UPDATE:  w_next = w_warm ? DIVIDE : IDLE;
            DIVIDE:  w_next = (r_step == 6'd44) ? DONE : DIVIDE;
            default: w_next = IDLE;
        endcase
    end
    assign price_ready = (r_state == IDLE);
    assign rsi_valid   = (r_state == DONE);
    assign rsi_        = r_rsi;
    assign warm        = r_warm;
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prev      <= '0;
            r_gain      <= '0;
            r_loss      <= '0;
            r_rsi       <= '0;
            r_have_prev <= 1'b0;
            r_warm      <= 1'b0;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_gsum      <= '0;
            r_lsum      <= '0;
            r_den       <= '0;
            r_rem       <= '0;
            r_num       <= '0;
            r_step      <= '0;
            for (int i = 0; i < WINDOW; i++) begin
                r_ring_g[i] <= '0;
                r_ring_l[i] <= '0;
            end
        end else begin
            if (r_state == IDLE && price_valid) begin
                r_prev      <= price_in;
                r_have_prev <= 1'b1;
                r_gain      <= (price_in > r_prev) ? price_in - r_prev : '0;
                r_loss      <= (price_in < r_prev) ? r_prev - price_in : '0;
            end
            if (r_state == UPDATE) begin
                r_ring_g[r_ptr] <= r_gain;
                r_ring_l[r_ptr] <= r_loss;
                r_ptr  <= (r_ptr == PW'(WINDOW - 1)) ? '0 : r_ptr + 1'b1;
                r_cnt  <= (r_cnt == CW'(WINDOW)) ? r_cnt : r_cnt + 1'b1;
                r_gsum <= w_gsum;
                r_lsum <= w_lsum;
                r_warm <= w_warm;
                r_num  <= w_num;
                r_den  <= w_den;
                r_rem  <= '0;
                r_step <= '0;
            end
            // quotient bits shift into r_num from the bottom as the numerator shifts out the top
            if (r_state == DIVIDE) begin
                r_num  <= {r_num[43:0], w_ge};
                r_rem  <= w_ge ? 39'(w_trial - {1'b0, r_den}) : w_trial[38:0];
                r_step <= r_step + 1'b1;
                if (r_step == 6'd44)
                    r_rsi <= (r_den == '0) ? 32'd50 : {25'd0, r_num[5:0], w_ge};
            end
        end
    end
endmodule

// File: tb/tb_rsi_calc.sv
// tb_rsi_calc: directed and random price streams checked against a windowed-RSI reference model
module tb_rsi_calc;
    localparam int W = 14;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] price_in = '0;
    logic        price_valid = 1'b0;
    logic        price_ready;
    logic [31:0] rsi_;
    logic        rsi_valid;
    logic        warm;
    rsi_calc #(.WINDOW(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .price_in(price_in),
        .price_valid(price_valid),
        .price_ready(price_ready),
        .rsi_(rsi_),
        .rsi_valid(rsi_valid),
        .warm(warm)
    );
    always #5 clk = ~clk;
    int          n_pass = 0;
    int          n_fail = 0;
    int          n_total = 0;
    int          n_smp = 0;
    longint      deltas[$];
    bit          have_prev;
    logic [31:0] prev_p;
    int          n_delta;
    logic [31:0] exp_rsi;
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    function automatic longint ref_rsi();
        longint g = 0;
        longint l = 0;
        foreach (deltas[i]) begin
            if (deltas[i] > 0) g += deltas[i];
            else l -= deltas[i];
        end
        if (g + l == 0) return 50;
`ifdef RSI_ROUND_EN
        return (100 * g + (g + l) / 2) / (g + l);
`else
        return (100 * g) / (g + l);
`endif
    endfunction
    task automatic do_reset();
        rst_n = 1'b0;
        price_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        deltas.delete();
        have_prev = 0;
        n_delta = 0;
        exp_rsi = 0;
        check("rst_ready", price_ready, 1);
        check("rst_valid", rsi_valid, 0);
        check("rst_rsi", rsi_, 0);
        check("rst_warm", warm, 0);
    endtask
    task automatic send(input logic [31:0] p);
        int m, vcnt, vpos, exp_ready;
        bit exp_fire;
        logic [31:0] vrsi;
        string t;
        n_smp++;
        t = $sformatf("smp%0d", n_smp);
        exp_fire = 0;
        exp_ready = 0;
        if (have_prev) begin
            deltas.push_back(longint'(p) - longint'(prev_p));
            if (deltas.size() > W) void'(deltas.pop_front());
            n_delta++;
            exp_ready = 1;
            if (n_delta >= W) begin
                exp_fire = 1;
                exp_ready = 47;
                exp_rsi = 32'(ref_rsi());
            end
        end
        have_prev = 1;
        prev_p = p;
        price_in = p;
        price_valid = 1'b1;
        @(posedge clk);
        #1 price_valid = 1'b0;
        m = 0;
        vcnt = 0;
        vpos = -1;
        vrsi = '0;
        forever begin
            if (rsi_valid) begin
                vcnt++;
                vpos = m;
                vrsi = rsi_;
            end
            if (price_ready || m == 60) break;
            price_valid = 1'b1;
            price_in = $urandom;
            @(posedge clk);
            #1 m++;
        end
        price_valid = 1'b0;
        check({t, "_ready_lat"}, m, exp_ready);
        check({t, "_valid_cnt"}, vcnt, exp_fire);
        if (exp_fire) begin
            check({t, "_valid_pos"}, vpos, 46);
            check({t, "_rsi_pulse"}, vrsi, exp_rsi);
        end
        check({t, "_rsi_hold"}, rsi_, exp_rsi);
        check({t, "_warm"}, warm, n_delta >= W);
    endtask
    task automatic abort_mid_divide(input logic [31:0] p);
        int vcnt;
        price_in = p;
        price_valid = 1'b1;
        @(posedge clk);
        #1 price_valid = 1'b0;
        repeat (21) @(posedge clk);
        #1 check("abort_pre_valid", rsi_valid, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        deltas.delete();
        have_prev = 0;
        n_delta = 0;
        exp_rsi = 0;
        vcnt = 0;
        for (int i = 0; i < 60; i++) begin
            if (rsi_valid) vcnt++;
            @(posedge clk);
            #1;
        end
        check("abort_valid_cnt", vcnt, 0);
        check("abort_rsi", rsi_, 0);
        check("abort_warm", warm, 0);
        check("abort_ready", price_ready, 1);
    endtask
    initial begin
        do_reset();
        for (int i = 0; i < 15; i++) send(32'(100 + i));
        check("rising_rsi", rsi_, 100);
        do_reset();
        for (int i = 0; i < 15; i++) send(32'(200 - i));
        check("falling_rsi", rsi_, 0);
        do_reset();
        repeat (15) send(32'd500);
        check("flat_rsi", rsi_, 50);
        do_reset();
        for (int i = 0; i < 15; i++) send(32'((i % 2) ? 102 + (i - 1) / 2 : 100 + i / 2));
`ifdef RSI_ROUND_EN
        check("zigzag_rsi", rsi_, 67);
`else
        check("zigzag_rsi", rsi_, 66);
`endif
        do_reset();
        for (int i = 0; i < 15; i++) send(32'(100 + i));
        for (int i = 0; i < 7; i++) send(32'(113 - i));
        check("wrap22_rsi", rsi_, 50);
        for (int i = 7; i < 14; i++) send(32'(113 - i));
        check("wrap29_rsi", rsi_, 0);
        do_reset();
        for (int i = 0; i < 50; i++) send((i < 25) ? 32'($urandom_range(0, 5000)) : $urandom);
        abort_mid_divide(32'd7);
        for (int i = 0; i < 14; i++) send(32'($urandom_range(0, 1000)));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
